// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: load-use bubbles, branch flushes,
// memory freeze, link-aware operand forwarding and stall counting.
module hazard_scoreboard #(
  parameter int REG_AW     = 4,
  parameter int LOAD_LAT   = 1,
  parameter int LINK_REG   = 14,
  parameter int LINK_BLOCK = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              MemtoRegE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              isBLE,
  input  logic              WLinkM,
  input  logic              WLinkW,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  input  logic              PCSrcW,
  input  logic              BranchTakenE,
  input  logic              MemBusyM,
  input  logic              ClrCount,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              FwdLinkAM,
  output logic              FwdLinkBM,
  output logic              LdStallActive,
  output logic [15:0]       StallCount
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] LDSTALL = 1'b1;
  localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 2);
  localparam logic [REG_AW-1:0] LINK_A = REG_AW'(LINK_REG);

  logic [0:0]            state;
  logic [1:0]            cnt;
  logic [LINK_BLOCK-1:0] lsr;
  logic                  freeze;
  logic                  ldHit;
  logic                  pcPend;
  logic                  ldStall;
  logic                  linkBlk;
  logic                  stallFRaw;

  assign freeze  = MemBusyM;
  assign ldHit   = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign pcPend  = PCSrcD | PCSrcE | PCSrcM;
  assign ldStall = (ldHit & (state == IDLE)) | (state == LDSTALL);
  assign linkBlk = |lsr;
  assign stallFRaw = ldStall | pcPend;
  assign LdStallActive = (state == LDSTALL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      lsr   <= '0;
    end else if (!freeze) begin
      lsr <= (lsr << 1) | LINK_BLOCK'(isBLE);
      unique case (state)
        IDLE: begin
          if (ldHit && !BranchTakenE && LOAD_LAT > 1) begin
            state <= LDSTALL;
            cnt   <= CNT_INIT;
          end
        end
        default: begin
          if (BranchTakenE) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 2'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
      endcase
    end
  end

  // Clear wins even while the pipeline is frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
    end else if (ClrCount) begin
      StallCount <= '0;
    end else if (!freeze && stallFRaw &&
                 StallCount != 16'hFFFF) begin
      StallCount <= StallCount + 16'd1;
    end
  end

  always_comb begin
    StallF = stallFRaw;
    StallD = ldStall & ~BranchTakenE;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = pcPend | PCSrcW | BranchTakenE;
    FlushE = ldStall | BranchTakenE;
    if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
    end
  end

  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] ra
  );
    logic fm, fw, lm, lw;
    fm = (ra == WA3M) & RegWriteM & ~linkBlk;
    fw = (ra == WA3W) & RegWriteW & ~linkBlk;
    lm = WLinkM & RegWriteM & (ra == LINK_A);
    lw = WLinkW & RegWriteW & (ra == LINK_A);
    if (fm)           return 2'b10;
    else if (fw)      return 2'b01;
    else if (lm | lw) return 2'b11;
    else              return 2'b00;
  endfunction

  assign ForwardAE = fwdSel(RA1E);
  assign ForwardBE = fwdSel(RA2E);
  assign FwdLinkAM = WLinkM & RegWriteM & (RA1E == LINK_A);
  assign FwdLinkBM = WLinkM & RegWriteM & (RA2E == LINK_A);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a
// bubble/blocking-window reference model.
module tb_hazard_scoreboard;

  localparam int AW  = 4;
  localparam int LAT = 3;
  localparam int LR  = 14;
  localparam int LB  = 2;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] RA1D, RA2D, RA1E, RA2E;
  logic [AW-1:0] WA3E, WA3M, WA3W;
  logic MemtoRegE, RegWriteM, RegWriteW, isBLE;
  logic WLinkM, WLinkW;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic BranchTakenE, MemBusyM, ClrCount;
  logic StallF, StallD, StallE, StallM;
  logic FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic FwdLinkAM, FwdLinkBM, LdStallActive;
  logic [15:0] StallCount;

  hazard_scoreboard #(
    .REG_AW(AW), .LOAD_LAT(LAT),
    .LINK_REG(LR), .LINK_BLOCK(LB)
  ) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D),
    .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .MemtoRegE(MemtoRegE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .isBLE(isBLE),
    .WLinkM(WLinkM), .WLinkW(WLinkW),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
    .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE),
    .MemBusyM(MemBusyM), .ClrCount(ClrCount),
    .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .FwdLinkAM(FwdLinkAM), .FwdLinkBM(FwdLinkBM),
    .LdStallActive(LdStallActive),
    .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  // Model: bubbles still owed, cycles left in the BL window, count.
  int bub = 0;
  int blk = 0;
  int mcnt = 0;

  logic sF, sD, sE, sM, sFD, sFE, sLA, sLB, sAct;
  logic [1:0] sFA, sFB;
  logic [15:0] sCnt;

  task automatic chk(string nm, logic [15:0] a, logic [15:0] e);
    nCmp++;
    if (a !== e) begin
      nBad++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [1:0] mFwd(
    input logic [AW-1:0] ra, input logic lb
  );
    if (!lb && RegWriteM && ra == WA3M) return 2'b10;
    if (!lb && RegWriteW && ra == WA3W) return 2'b01;
    if (ra == AW'(LR) &&
        ((WLinkM && RegWriteM) || (WLinkW && RegWriteW)))
      return 2'b11;
    return 2'b00;
  endfunction

  task automatic tick();
    logic frz, hit, lds, pcp, lb;
    logic eF, eD, eS, eFD, eFE, eLA, eLB;
    logic [1:0] eA, eB;
    if (reset) begin
      bub = 0; blk = 0; mcnt = 0;
    end
    frz = MemBusyM;
    hit = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
    lds = (bub > 0) || hit;
    pcp = PCSrcD || PCSrcE || PCSrcM;
    lb  = (blk > 0);
    eS  = frz;
    eF  = frz ? 1'b1 : (lds || pcp);
    eD  = frz ? 1'b1 : (lds && !BranchTakenE);
    eFD = frz ? 1'b0 : (pcp || PCSrcW || BranchTakenE);
    eFE = frz ? 1'b0 : (lds || BranchTakenE);
    eA  = mFwd(RA1E, lb);
    eB  = mFwd(RA2E, lb);
    eLA = WLinkM && RegWriteM && RA1E == AW'(LR);
    eLB = WLinkM && RegWriteM && RA2E == AW'(LR);
    @(negedge clk);
    sF = StallF; sD = StallD; sE = StallE; sM = StallM;
    sFD = FlushD; sFE = FlushE; sFA = ForwardAE;
    sFB = ForwardBE; sLA = FwdLinkAM; sLB = FwdLinkBM;
    sAct = LdStallActive; sCnt = StallCount;
    chk("StallF", 16'(sF), 16'(eF));
    chk("StallD", 16'(sD), 16'(eD));
    chk("StallE", 16'(sE), 16'(eS));
    chk("StallM", 16'(sM), 16'(eS));
    chk("FlushD", 16'(sFD), 16'(eFD));
    chk("FlushE", 16'(sFE), 16'(eFE));
    chk("ForwardAE", 16'(sFA), 16'(eA));
    chk("ForwardBE", 16'(sFB), 16'(eB));
    chk("FwdLinkAM", 16'(sLA), 16'(eLA));
    chk("FwdLinkBM", 16'(sLB), 16'(eLB));
    chk("LdStallActive", 16'(sAct), 16'(bub > 0));
    chk("StallCount", sCnt, 16'(mcnt));
    @(posedge clk);
    if (!reset) begin
      if (ClrCount) mcnt = 0;
      else if (!frz && eF && mcnt < 65535) mcnt++;
      if (!frz) begin
        if (bub > 0) bub = BranchTakenE ? 0 : bub - 1;
        else if (hit && !BranchTakenE) bub = LAT - 1;
        if (isBLE) blk = LB;
        else if (blk > 0) blk--;
      end
    end
    #1;
  endtask

  task automatic idle();
    RA1D = 0; RA2D = 1; RA1E = 0; RA2E = 0;
    WA3E = 2; WA3M = 0; WA3W = 0;
    MemtoRegE = 0; RegWriteM = 0; RegWriteW = 0;
    isBLE = 0; WLinkM = 0; WLinkW = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
    BranchTakenE = 0; MemBusyM = 0; ClrCount = 0;
  endtask

  task automatic loadHit();
    MemtoRegE = 1; WA3E = 5; RA1D = 5;
  endtask

  task automatic clrCnt();
    ClrCount = 1; tick(); ClrCount = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    #2;
    tick();
    chk("rstAct", 16'(sAct), 16'd0);
    chk("rstCnt", sCnt, 16'd0);
    reset = 0;
    tick();

    // load-use hazard, three bubbles
    clrCnt();
    loadHit(); tick();
    chk("ld1F", 16'({sF, sD, sFE}), 16'b111);
    chk("ld1Act", 16'(sAct), 16'd0);
    idle();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("ldNF", 16'({sF, sD, sFE}), 16'b111);
      chk("ldNAct", 16'(sAct), 16'd1);
    end
    tick();
    chk("ldEndF", 16'({sF, sD, sFE}), 16'b000);
    chk("ldCnt", sCnt, 16'd3);

    // branch on second bubble
    loadHit(); tick(); idle();
    BranchTakenE = 1; tick();
    chk("brFlush", 16'({sFD, sFE}), 16'b11);
    chk("brStallD", 16'(sD), 16'd0);
    BranchTakenE = 0; tick();
    chk("brIdle", 16'({sAct, sD}), 16'b00);

    // freeze mid stall
    clrCnt();
    loadHit(); tick(); idle();
    MemBusyM = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("frzStall", 16'({sF, sD, sE, sM}), 16'hF);
      chk("frzFlush", 16'({sFD, sFE}), 16'd0);
      chk("frzCnt", sCnt, 16'd1);
    end
    MemBusyM = 0;
    tick(); chk("resume1", 16'({sD, sAct}), 16'b11);
    tick(); chk("resume2", 16'({sD, sAct}), 16'b11);
    tick(); chk("resumeEnd", 16'({sD, sAct}), 16'b00);
    chk("resumeCnt", sCnt, 16'd3);

    // reset aborts a stall
    loadHit(); tick(); idle();
    reset = 1; tick(); reset = 0;
    tick();
    chk("rstAbort", 16'({sAct, sD}), 16'b00);

    // BL blocks normal forwarding
    isBLE = 1; tick(); isBLE = 0;
    RA1E = 3; WA3M = 3; RegWriteM = 1;
    tick(); chk("blk1", 16'(sFA), 16'b00);
    tick(); chk("blk2", 16'(sFA), 16'b00);
    tick(); chk("blk3", 16'(sFA), 16'b10);
    idle();

    // link forwarding from M and W
    tick();
    RA2E = 14; WLinkM = 1; RegWriteM = 1; WA3M = 2;
    tick();
    chk("lnkM", 16'({sFB, sLB}), 16'b111);
    idle();
    RA2E = 14; WLinkW = 1; RegWriteW = 1; WA3W = 2;
    tick();
    chk("lnkW", 16'({sFB, sLB}), 16'b110);
    idle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      RA1D = AW'($urandom_range(0, 3));
      RA2D = AW'($urandom_range(0, 3));
      RA1E = ($urandom_range(0, 4) == 0) ? AW'(LR)
                                         : AW'($urandom_range(0, 3));
      RA2E = ($urandom_range(0, 4) == 0) ? AW'(LR)
                                         : AW'($urandom_range(0, 3));
      WA3E = AW'($urandom_range(0, 3));
      WA3M = AW'($urandom_range(0, 3));
      WA3W = AW'($urandom_range(0, 3));
      MemtoRegE = ($urandom_range(0, 2) == 0);
      RegWriteM = $urandom_range(0, 1);
      RegWriteW = $urandom_range(0, 1);
      isBLE = ($urandom_range(0, 7) == 0);
      WLinkM = ($urandom_range(0, 3) == 0);
      WLinkW = ($urandom_range(0, 3) == 0);
      PCSrcD = ($urandom_range(0, 9) == 0);
      PCSrcE = ($urandom_range(0, 9) == 0);
      PCSrcM = ($urandom_range(0, 9) == 0);
      PCSrcW = ($urandom_range(0, 9) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      MemBusyM = ($urandom_range(0, 5) == 0);
      ClrCount = ($urandom_range(0, 49) == 0);
      tick();
    end
    reset = 0;
    idle();
    tick(); tick(); tick(); tick();

    // saturation, clear, async reset
    PCSrcD = 1;
    repeat (70000) @(posedge clk);
    #1;
    mcnt = (mcnt + 70000 > 65535) ? 65535 : mcnt + 70000;
    blk = 0;
    tick();
    chk("satCnt", sCnt, 16'hFFFF);
    clrCnt();
    tick();
    chk("clrCnt", sCnt, 16'd0);
    tick(); tick();
    reset = 1;
    #1;
    chk("rstAsync", StallCount, 16'd0);
    tick();
    reset = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
